// File: rtl/truth_table_scanner.sv
// Sequential truth-table reader for a small combinational block. It steps through every
// input vector, samples the block's output and compares the captured table with a golden one.
module truth_table_scanner #(
  parameter int unsigned N_IN          = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_s,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 match,
  output logic [N_IN:0]        mismatch_count
);

  localparam int unsigned TBL_W = 2**N_IN;
  localparam int unsigned LAST  = TBL_W - 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t             state;
  logic [N_IN-1:0]    idx;
  logic [CNT_W-1:0]   cnt;
  logic [TBL_W-1:0]   exp_q;

  // idx is the vector currently presented to the block, so it doubles as dut_in
  assign dut_in = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      exp_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      match          <= 1'b0;
      table_out      <= '0;
      mismatch_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q          <= expected;
            table_out      <= '0;
            mismatch_count <= '0;
            match          <= 1'b0;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b1;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          table_out[idx] <= dut_s;
          if (dut_s != exp_q[idx]) begin
            mismatch_count <= mismatch_count + (N_IN+1)'(1);
          end
          // the last vector ends the scan; idx is left at its final value
          if (idx == N_IN'(LAST)) begin
            state <= DONE;
          end else begin
            idx   <= idx + N_IN'(1);
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          match <= (mismatch_count == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: directed vector table, randomized tables against a
// popcount reference, restart/reset corner cases and a SETTLE_CYCLES=1 drive trace.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] expected, dut_tbl;

  logic        dut_s0, busy0, done0, match0;
  logic [3:0]  dut_in0;
  logic [15:0] table0;
  logic [4:0]  mm0;

  logic        dut_s1, busy1, done1, match1;
  logic [3:0]  dut_in1;
  logic [15:0] table1;
  logic [4:0]  mm1;

  int passed = 0;
  int total  = 0;

  // behavioural stand-in for the combinational function under test
  assign dut_s0 = dut_tbl[dut_in0];
  assign dut_s1 = dut_tbl[dut_in1];

  always #5 clk = ~clk;

  truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(2)) u_scan0 (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_s(dut_s0),
    .dut_in(dut_in0), .busy(busy0), .done(done0), .table_out(table0),
    .match(match0), .mismatch_count(mm0)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(1)) u_scan1 (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_s(dut_s1),
    .dut_in(dut_in1), .busy(busy1), .done(done1), .table_out(table1),
    .match(match1), .mismatch_count(mm1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Run one scan on u_scan0 and compare against the reference outcome.
  // p1/p2: cycle numbers at which start is re-pulsed (with expected changed to exp_mid).
  task automatic scan(input string tag, input logic [15:0] tbl, input logic [15:0] exp,
                      input int p1, input int p2, input logic [15:0] exp_mid);
    int lat;
    int ndone;
    int ref_cnt;
    lat   = -1;
    ndone = 0;
    dut_tbl  = tbl;
    expected = exp;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy0), 32'd1);
    for (int k = 1; k <= 60; k++) begin
      if (k == p1 || k == p2) begin
        start    = 1'b1;
        expected = exp_mid;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done0) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    ref_cnt = $countones(tbl ^ exp);
    check({tag, "_latency"}, 32'(lat), 32'd49);
    check({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    check({tag, "_table"}, 32'(table0), 32'(tbl));
    check({tag, "_count"}, 32'(mm0), 32'(ref_cnt));
    check({tag, "_match"}, 32'(match0), 32'(ref_cnt == 0));
    check({tag, "_busy_end"}, 32'(busy0), 32'd0);
    check({tag, "_dut_in_end"}, 32'(dut_in0), 32'd15);
  endtask

  typedef struct {
    logic [15:0] tbl;
    logic [15:0] exp;
    int          cnt;
    logic        m;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat1;
    logic [15:0] rt, re;

    vecs[0] = '{16'h212F, 16'h212F, 0,  1'b1};
    vecs[1] = '{16'h212F, 16'h0000, 7,  1'b0};
    vecs[2] = '{16'h0000, 16'hFFFF, 16, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 0,  1'b1};
    vecs[4] = '{16'h8001, 16'h0001, 1,  1'b0};

    rst_n = 1'b0; start = 1'b0; expected = '0; dut_tbl = '0;
    #1;
    check("rst_dut_in", 32'(dut_in0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_match", 32'(match0), 32'd0);
    check("rst_table", 32'(table0), 32'd0);
    check("rst_count", 32'(mm0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 5; i++) begin
      scan($sformatf("vec%0d", i), vecs[i].tbl, vecs[i].exp, -1, -1, vecs[i].exp);
      check($sformatf("vec%0d_tab_count", i), 32'(mm0), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_tab_match", i), 32'(match0), 32'(vecs[i].m));
    end

    // randomized tables against the popcount reference
    for (int i = 0; i < 8; i++) begin
      rt = 16'($urandom);
      re = (i % 3 == 0) ? rt : 16'($urandom);
      scan($sformatf("rnd%0d", i), rt, re, -1, -1, re);
    end

    // start re-pulsed mid-scan with a changed expected: must be ignored
    scan("restart", 16'h212F, 16'h212F, 5, 30, 16'h0000);

    // reset at cycle 20 of a scan
    dut_tbl  = 16'h212F;
    expected = 16'h0000;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_table", 32'(table0), 32'd0);
    check("midrst_count", 32'(mm0), 32'd0);
    check("midrst_dut_in", 32'(dut_in0), 32'd0);
    check("midrst_match", 32'(match0), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 60; k++) begin
        @(posedge clk);
        #1 if (done0 || busy0) seen++;
      end
      check("midrst_no_done", 32'(seen), 32'd0);
    end
    scan("rescan", 16'h212F, 16'h212F, -1, -1, 16'h212F);

    // SETTLE_CYCLES=1: each vector held two cycles, done at start+33
    dut_tbl  = 16'h212F;
    expected = 16'h212F;
    lat1 = -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("s1_dut_in_k0", 32'(dut_in1), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k <= 32) check($sformatf("s1_dut_in_k%0d", k), 32'(dut_in1), 32'((k / 2 > 15) ? 15 : k / 2));
      if (done1 && lat1 < 0) lat1 = k;
    end
    check("s1_latency", 32'(lat1), 32'd33);
    check("s1_table", 32'(table1), 32'h212F);
    check("s1_match", 32'(match1), 32'd1);
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
